// File: rtl/tensor_processing_cluster_pkg.sv
// tensor_processing_cluster_pkg: opcodes, instruction field positions, sequencer states and lane helpers.
package tensor_processing_cluster_pkg;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_TENSOR = 8'h01;
  localparam logic [7:0] OP_HALT = 8'hFF;
  localparam logic [7:0] SUB_GEMM = 8'h01;
  localparam int OPC_LSB = 120;
  localparam int SUB_LSB = 112;
  localparam int DST_LSB = 96;
  localparam int ACT_LSB = 80;
  localparam int WGT_LSB = 64;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_GEMM_LDW, S_GEMM_ROW, S_DONE} state_t;
  function automatic logic [31:0] sx8(logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction
endpackage

// File: rtl/tensor_processing_cluster_sram_bank.sv
// sram_bank: single-port bank, synchronous write, one-cycle registered read.
module sram_bank
  import tensor_processing_cluster_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
    if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/tensor_processing_cluster.sv
// tensor_processing_cluster: instruction sequencer running int8 GEMM tiles over a banked SRAM.
module tensor_processing_cluster
  import tensor_processing_cluster_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int SRAM_WIDTH = 256,
  parameter int SRAM_BANKS = 4,
  parameter int SRAM_DEPTH = 256,
  parameter int VPU_LANES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tpc_start,
  input  logic [19:0]           tpc_start_pc,
  output logic                  tpc_busy,
  output logic                  tpc_done,
  output logic                  tpc_error,
  input  logic                  global_sync_in,
  output logic                  sync_request,
  input  logic                  sync_grant,
  input  logic [SRAM_WIDTH-1:0] noc_rx_data,
  input  logic [19:0]           noc_rx_addr,
  input  logic                  noc_rx_valid,
  output logic                  noc_rx_ready,
  input  logic                  noc_rx_is_instr,
  output logic [SRAM_WIDTH-1:0] noc_tx_data,
  output logic [19:0]           noc_tx_addr,
  output logic                  noc_tx_valid,
  input  logic                  noc_tx_ready,
  output logic [39:0]           axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [255:0]          axi_wdata,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [39:0]           axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [255:0]          axi_rdata,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);
  localparam int AW = $clog2(SRAM_DEPTH);
  localparam int BW = $clog2(SRAM_BANKS);
  localparam int RW = $clog2(ARRAY_SIZE);
  localparam int LW = 8 * ARRAY_SIZE;
  state_t state, state_n;
  logic [7:0] pc, pc_n;
  logic [RW-1:0] row, row_n;
  logic ph, ph_n, err, err_n, start_seen, accept, noc_wr, unused_ok;
  logic [127:0] instr_mem [256];
  logic [127:0] ir;
  logic [7:0] op, sub;
  logic [ARRAY_SIZE-1:0][LW-1:0] w;
  logic [15:0] dst, act, wgt, ra, da;
  logic [15:0] wa [ARRAY_SIZE];
  logic [SRAM_BANKS-1:0] b_en, b_we;
  logic [AW-1:0] b_addr [SRAM_BANKS];
  logic [SRAM_WIDTH-1:0] b_wdata [SRAM_BANKS];
  logic [SRAM_WIDTH-1:0] rdata [SRAM_BANKS];
  logic [SRAM_WIDTH-1:0] arow, c_word, rd_xor;
  assign op = ir[OPC_LSB+:8];
  assign sub = ir[SUB_LSB+:8];
  assign dst = ir[DST_LSB+:16];
  assign act = ir[ACT_LSB+:16];
  assign wgt = ir[WGT_LSB+:16];
  assign ra = act + 16'(row);
  assign da = dst + 16'(row);
  assign arow = rdata[ra[BW-1:0]];
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : wa_gen
    assign wa[j] = wgt + 16'(j);
  end
  assign tpc_busy = !(state == S_IDLE || state == S_DONE);
  assign tpc_done = state == S_DONE;
  assign tpc_error = err;
  assign noc_rx_ready = !tpc_busy;
  assign noc_wr = noc_rx_valid && noc_rx_ready;
  // start_seen makes a held start launch exactly once
  assign accept = tpc_start && !start_seen && !tpc_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc <= '0;
      row <= '0;
      ph <= 1'b0;
      err <= 1'b0;
      start_seen <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      row <= row_n;
      ph <= ph_n;
      err <= err_n;
      start_seen <= tpc_start && (start_seen || accept);
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    row_n = row;
    ph_n = ph;
    err_n = err;
    case (state)
      S_IDLE, S_DONE: if (accept) begin
        state_n = S_FETCH;
        pc_n = tpc_start_pc[7:0];
        err_n = 1'b0;
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        pc_n = pc + 8'd1;
        state_n = op == OP_NOP ? S_FETCH : (op == OP_TENSOR && sub == SUB_GEMM) ? S_GEMM_LDW : S_DONE;
        err_n = !(op == OP_NOP || op == OP_HALT || (op == OP_TENSOR && sub == SUB_GEMM));
      end
      S_GEMM_LDW: begin
        ph_n = !ph;
        row_n = '0;
        state_n = ph ? S_GEMM_ROW : S_GEMM_LDW;
      end
      S_GEMM_ROW: begin
        ph_n = !ph;
        row_n = ph ? row + 1'b1 : row;
        state_n = (ph && row == RW'(ARRAY_SIZE - 1)) ? S_FETCH : S_GEMM_ROW;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (noc_wr && noc_rx_is_instr) instr_mem[noc_rx_addr[7:0]] <= noc_rx_data[127:0];
    if (state == S_FETCH) ir <= instr_mem[pc];
    if (state == S_GEMM_LDW && ph)
      for (int j = 0; j < ARRAY_SIZE; j++) w[j] <= rdata[wa[j][BW-1:0]][LW-1:0];
  end
  always_comb begin
    c_word = '0;
    for (int j = 0; j < ARRAY_SIZE; j++)
      for (int k = 0; k < ARRAY_SIZE; k++)
        c_word[32*j+:32] = c_word[32*j+:32] + sx8(arow[8*k+:8]) * sx8(w[j][8*k+:8]);
  end
  // NoC owns the banks while idle; the sequencer owns them while busy
  always_comb begin
    b_en = '0;
    b_we = '0;
    for (int b = 0; b < SRAM_BANKS; b++) begin
      b_addr[b] = '0;
      b_wdata[b] = '0;
    end
    if (noc_wr && !noc_rx_is_instr) begin
      b_en[noc_rx_addr[BW-1:0]] = 1'b1;
      b_we[noc_rx_addr[BW-1:0]] = 1'b1;
      b_addr[noc_rx_addr[BW-1:0]] = noc_rx_addr[BW+AW-1:BW];
      b_wdata[noc_rx_addr[BW-1:0]] = noc_rx_data;
    end
    if (state == S_GEMM_LDW && !ph)
      for (int j = 0; j < ARRAY_SIZE; j++) begin
        b_en[wa[j][BW-1:0]] = 1'b1;
        b_addr[wa[j][BW-1:0]] = wa[j][BW+AW-1:BW];
      end
    if (state == S_GEMM_ROW && ph) begin
      b_en[da[BW-1:0]] = 1'b1;
      b_we[da[BW-1:0]] = 1'b1;
      b_addr[da[BW-1:0]] = da[BW+AW-1:BW];
      b_wdata[da[BW-1:0]] = c_word;
    end
    if (state == S_GEMM_ROW && !ph) begin
      b_en[ra[BW-1:0]] = 1'b1;
      b_addr[ra[BW-1:0]] = ra[BW+AW-1:BW];
    end
  end
  if (1) begin : sram_inst
    for (genvar b = 0; b < SRAM_BANKS; b++) begin : bank_gen
      sram_bank #(.WIDTH(SRAM_WIDTH), .DEPTH(SRAM_DEPTH)) bank_inst (
        .clk(clk), .en(b_en[b]), .we(b_we[b]), .addr(b_addr[b]), .wdata(b_wdata[b]), .rdata(rdata[b])
      );
    end
  end
  always_comb begin
    rd_xor = '0;
    for (int b = 0; b < SRAM_BANKS; b++) rd_xor = rd_xor ^ rdata[b];
  end
  assign unused_ok = ^{global_sync_in, sync_grant, noc_tx_ready, axi_awready, axi_arready, axi_wready,
    axi_bvalid, axi_rvalid, axi_rlast, axi_bresp, axi_rdata, tpc_start_pc[19:8],
    noc_rx_addr[19:BW+AW], ir[63:0], rd_xor, arow[SRAM_WIDTH-1:LW], VPU_LANES != 0};
  assign sync_request = 1'b0;
  assign noc_tx_data = '0;
  assign noc_tx_addr = '0;
  assign noc_tx_valid = 1'b0;
  assign axi_awaddr = '0;
  assign axi_awlen = '0;
  assign axi_awvalid = 1'b0;
  assign axi_wdata = '0;
  assign axi_wlast = 1'b0;
  assign axi_wvalid = 1'b0;
  assign axi_bready = 1'b0;
  assign axi_araddr = '0;
  assign axi_arlen = '0;
  assign axi_arvalid = 1'b0;
  assign axi_rready = 1'b0;
endmodule

// File: tb/tb_tensor_processing_cluster.sv
// tb_tensor_processing_cluster: directed GEMM programs with hand-computed results.
module tb_tensor_processing_cluster;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tpc_start = 1'b0, tpc_busy, tpc_done, tpc_error;
  logic [19:0] tpc_start_pc = '0;
  logic sync_request;
  logic [255:0] noc_rx_data = '0, noc_tx_data, axi_wdata;
  logic [19:0] noc_rx_addr = '0, noc_tx_addr;
  logic noc_rx_valid = 1'b0, noc_rx_ready, noc_rx_is_instr = 1'b0, noc_tx_valid;
  logic [39:0] axi_awaddr, axi_araddr;
  logic [7:0] axi_awlen, axi_arlen;
  logic axi_awvalid, axi_arvalid, axi_wvalid, axi_wlast, axi_bready, axi_rready;
  int checks = 0, failures = 0;
  logic both_seen = 1'b0;

  always #5 clk = ~clk;

  tensor_processing_cluster dut (
    .clk(clk), .rst_n(rst_n), .tpc_start(tpc_start), .tpc_start_pc(tpc_start_pc),
    .tpc_busy(tpc_busy), .tpc_done(tpc_done), .tpc_error(tpc_error),
    .global_sync_in(1'b0), .sync_request(sync_request), .sync_grant(1'b0),
    .noc_rx_data(noc_rx_data), .noc_rx_addr(noc_rx_addr), .noc_rx_valid(noc_rx_valid),
    .noc_rx_ready(noc_rx_ready), .noc_rx_is_instr(noc_rx_is_instr),
    .noc_tx_data(noc_tx_data), .noc_tx_addr(noc_tx_addr), .noc_tx_valid(noc_tx_valid), .noc_tx_ready(1'b0),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(1'b0),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(1'b0),
    .axi_bresp(2'b00), .axi_bvalid(1'b0), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(1'b0),
    .axi_rdata(256'h0), .axi_rlast(1'b0), .axi_rvalid(1'b0), .axi_rready(axi_rready)
  );

  always @(negedge clk) if (tpc_busy && tpc_done) both_seen <= 1'b1;

  function automatic logic [255:0] p8(int b0, int b1, int b2, int b3);
    return {224'h0, 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction
  function automatic logic [255:0] r32(int c0, int c1, int c2, int c3);
    return {128'h0, 32'(c3), 32'(c2), 32'(c1), 32'(c0)};
  endfunction
  function automatic logic [255:0] gemm(logic [15:0] d, logic [15:0] a, logic [15:0] wt);
    return {128'h0, 8'h01, 8'h01, d, a, wt, 64'h0};
  endfunction
  function automatic logic [255:0] sram_rd(logic [15:0] a);
    case (a[1:0])
      2'd0: return dut.sram_inst.bank_gen[0].bank_inst.mem[a[9:2]];
      2'd1: return dut.sram_inst.bank_gen[1].bank_inst.mem[a[9:2]];
      2'd2: return dut.sram_inst.bank_gen[2].bank_inst.mem[a[9:2]];
      default: return dut.sram_inst.bank_gen[3].bank_inst.mem[a[9:2]];
    endcase
  endfunction

  task automatic noc_wr(input logic [19:0] a, input logic [255:0] d, input logic ins);
    @(negedge clk);
    noc_rx_addr = a;
    noc_rx_data = d;
    noc_rx_is_instr = ins;
    noc_rx_valid = 1'b1;
    @(negedge clk);
    noc_rx_valid = 1'b0;
  endtask

  task automatic run(input int pc, input int limit, output int cyc, output logic busy1, output logic rdy1);
    @(negedge clk);
    tpc_start = 1'b1;
    tpc_start_pc = 20'(pc);
    @(negedge clk);
    tpc_start = 1'b0;
    busy1 = tpc_busy;
    rdy1 = noc_rx_ready;
    cyc = 1;
    while (!tpc_done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < 4; i++) begin
      noc_wr(20'(i), p8(0, 0, 0, 0) | (256'h1 << (8 * i)), 1'b0);
      noc_wr(20'(16 + i), p8(i + 1, i + 5, i + 9, i + 13), 1'b0);
      noc_wr(20'(64 + i), p8(0, 0, 0, 0) | (256'h2 << (8 * i)), 1'b0);
      noc_wr(20'(80 + i), p8(1, 2, 3, 4), 1'b0);
      noc_wr(20'(128 + i), p8(0, 0, 0, 0) | (256'hFF << (8 * i)), 1'b0);
    end
    noc_wr(20'h90, p8(-128, 0, 0, 0), 1'b0);
    noc_wr(20'h91, p8(100, 3, 0, 0), 1'b0);
    noc_wr(20'h92, p8(0, 0, -5, 0), 1'b0);
    noc_wr(20'h93, p8(0, 0, 0, 7), 1'b0);
    noc_wr(20'd0, gemm(16'h20, 16'h00, 16'h10), 1'b1);
    noc_wr(20'd1, {128'h0, 8'hFF, 120'h0}, 1'b1);
    noc_wr(20'd4, gemm(16'h20, 16'h00, 16'h10), 1'b1);
    noc_wr(20'd5, gemm(16'h60, 16'h40, 16'h50), 1'b1);
    noc_wr(20'd6, {128'h0, 8'hFF, 120'h0}, 1'b1);
    noc_wr(20'd10, gemm(16'hA0, 16'h80, 16'h90), 1'b1);
    noc_wr(20'd11, {128'h0, 8'hFF, 120'h0}, 1'b1);
    noc_wr(20'd20, {128'h0, 8'h07, 120'h0}, 1'b1);
    noc_wr(20'd21, {128'h0, 8'h01, 8'h05, 112'h0}, 1'b1);
    noc_wr(20'd255, 256'h0, 1'b1);
  endtask

  task automatic test_reset();
    logic [1023:0] tied;
    repeat (3) @(negedge clk);
    tied = {sync_request, noc_tx_valid, axi_awvalid, axi_arvalid, axi_wvalid, axi_wlast, axi_bready, axi_rready,
            noc_tx_addr, axi_awaddr, axi_araddr, axi_awlen, axi_arlen, noc_tx_data, axi_wdata};
    checks++;
    if ({tpc_busy, tpc_done, tpc_error} !== 3'b000)
      $display("FAIL reset_status got=%b exp=000", {tpc_busy, tpc_done, tpc_error});
    checks++;
    if (tied !== '0) begin failures++; $display("FAIL reset_tied got=%h exp=0", tied); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (noc_rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", noc_rx_ready); end
    if ({tpc_busy, tpc_done, tpc_error} !== 3'b000) failures++;
  endtask

  task automatic test_gemm_identity();
    int cyc;
    logic b1, r1;
    for (int i = 0; i < 4; i++) noc_wr(20'(32 + i), '1, 1'b0);
    run(0, 100, cyc, b1, r1);
    checks++;
    if (b1 !== 1'b1 || r1 !== 1'b0) begin failures++; $display("FAIL id_busy got=%b%b exp=10", b1, r1); end
    checks++;
    if (tpc_done !== 1'b1 || cyc > 40) begin failures++; $display("FAIL id_latency got=%0d done=%b exp<=40", cyc, tpc_done); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sram_rd(16'(32 + i)) !== r32(4 * i + 1, 4 * i + 2, 4 * i + 3, 4 * i + 4)) begin
        failures++;
        $display("FAIL id_row%0d got=%h exp=%h", i, sram_rd(16'(32 + i)), r32(4 * i + 1, 4 * i + 2, 4 * i + 3, 4 * i + 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic b1, r1;
    for (int i = 0; i < 4; i++) noc_wr(20'(96 + i), '1, 1'b0);
    noc_wr(20'h64, {8{32'hA5A5_5A5A}}, 1'b0);
    run(4, 100, cyc, b1, r1);
    checks++;
    if (tpc_done !== 1'b1 || tpc_busy !== 1'b0 || cyc > 100)
      begin failures++; $display("FAIL b2b_done got=%b cyc=%0d exp=1", tpc_done, cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sram_rd(16'(96 + i)) !== r32(2 * (i + 1), 2 * (i + 1), 2 * (i + 1), 2 * (i + 1))) begin
        failures++;
        $display("FAIL b2b_row%0d got=%h exp=%h", i, sram_rd(16'(96 + i)), r32(2 * (i + 1), 2 * (i + 1), 2 * (i + 1), 2 * (i + 1)));
      end
      checks++;
      if (sram_rd(16'(32 + i)) !== r32(4 * i + 1, 4 * i + 2, 4 * i + 3, 4 * i + 4)) begin
        failures++;
        $display("FAIL b2b_first%0d got=%h", i, sram_rd(16'(32 + i)));
      end
    end
    checks++;
    if (sram_rd(16'h64) !== {8{32'hA5A5_5A5A}}) begin failures++; $display("FAIL b2b_neighbor got=%h", sram_rd(16'h64)); end
  endtask

  task automatic test_signed();
    int cyc;
    logic b1, r1;
    logic [255:0] exp [4];
    exp[0] = r32(128, -100, 0, 0);
    exp[1] = r32(0, -3, 0, 0);
    exp[2] = r32(0, 0, 5, 0);
    exp[3] = r32(0, 0, 0, -7);
    for (int i = 0; i < 4; i++) noc_wr(20'(160 + i), '1, 1'b0);
    run(10, 100, cyc, b1, r1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sram_rd(16'(160 + i)) !== exp[i]) begin
        failures++;
        $display("FAIL signed_row%0d got=%h exp=%h", i, sram_rd(16'(160 + i)), exp[i]);
      end
    end
  endtask

  task automatic test_error();
    int cyc;
    logic b1, r1;
    run(20, 50, cyc, b1, r1);
    checks++;
    if (tpc_error !== 1'b1 || tpc_busy !== 1'b0) begin failures++; $display("FAIL err_opcode got=%b%b exp=10", tpc_error, tpc_busy); end
    run(21, 50, cyc, b1, r1);
    checks++;
    if (tpc_error !== 1'b1 || tpc_busy !== 1'b0) begin failures++; $display("FAIL err_subop got=%b%b exp=10", tpc_error, tpc_busy); end
    run(0, 100, cyc, b1, r1);
    checks++;
    if (tpc_error !== 1'b0 || tpc_done !== 1'b1) begin failures++; $display("FAIL err_clear got=%b%b exp=01", tpc_error, tpc_done); end
  endtask

  task automatic test_pc_wrap();
    int cyc;
    logic b1, r1;
    noc_wr(20'd32, '1, 1'b0);
    run(255, 100, cyc, b1, r1);
    checks++;
    if (tpc_done !== 1'b1 || tpc_error !== 1'b0 || sram_rd(16'd32) !== r32(1, 2, 3, 4))
      begin failures++; $display("FAIL pc_wrap got=%b%b %h", tpc_done, tpc_error, sram_rd(16'd32)); end
  endtask

  task automatic test_start_held();
    @(negedge clk);
    tpc_start = 1'b1;
    tpc_start_pc = 20'd0;
    repeat (5) @(negedge clk);
    checks++;
    if (tpc_busy !== 1'b1) begin failures++; $display("FAIL held_busy got=%b exp=1", tpc_busy); end
    repeat (40) @(negedge clk);
    checks++;
    if (tpc_done !== 1'b1 || tpc_busy !== 1'b0) begin failures++; $display("FAIL held_once got=%b%b exp=10", tpc_done, tpc_busy); end
    tpc_start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic b1, r1;
    @(negedge clk);
    tpc_start = 1'b1;
    tpc_start_pc = 20'd4;
    @(negedge clk);
    tpc_start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tpc_busy, tpc_done, tpc_error} !== 3'b000)
      begin failures++; $display("FAIL mid_reset got=%b exp=000", {tpc_busy, tpc_done, tpc_error}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) noc_wr(20'(96 + i), 256'h0, 1'b0);
    run(4, 100, cyc, b1, r1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sram_rd(16'(96 + i)) !== r32(2 * (i + 1), 2 * (i + 1), 2 * (i + 1), 2 * (i + 1)))
        begin failures++; $display("FAIL restart_row%0d got=%h", i, sram_rd(16'(96 + i))); end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_seen !== 1'b0) begin failures++; $display("FAIL busy_done_overlap got=%b exp=0", both_seen); end
  endtask

  initial begin
    test_reset();
    load_all();
    test_gemm_identity();
    test_back_to_back();
    test_signed();
    test_error();
    test_pc_wrap();
    test_start_held();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tensor_processing_cluster.md
TENSOR_PROCESSING_CLUSTER -- requirements
Module: tensor_processing_cluster

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 ARRAY_SIZE 4: GEMM tile dimension.
 SRAM_WIDTH 256: SRAM word width in bits.
 SRAM_BANKS 4: number of SRAM banks.
 SRAM_DEPTH 256: words per bank.
 VPU_LANES 16: reserved, no function in this revision.
REQ-002 Ports (name direction width meaning):
 clk in 1 sole clock; rst_n in 1 reset, asynchronous, active-low.
 tpc_start in 1 start request; tpc_start_pc in 20 first instruction index.
 tpc_busy/tpc_done/tpc_error out 1 each: status.
 global_sync_in in 1; sync_request out 1; sync_grant in 1: barrier hooks, unused.
 noc_rx_data in SRAM_WIDTH; noc_rx_addr in 20; noc_rx_valid in 1; noc_rx_ready out 1; noc_rx_is_instr in 1: NoC write-in.
 noc_tx_data out SRAM_WIDTH; noc_tx_addr out 20; noc_tx_valid out 1; noc_tx_ready in 1.
 AXI master: axi_awaddr/axi_araddr out 40; axi_awlen/axi_arlen out 8; axi_awvalid/axi_arvalid/axi_wvalid/axi_wlast/axi_bready/axi_rready out 1; axi_wdata out 256; axi_awready/axi_arready/axi_wready/axi_bvalid/axi_rvalid/axi_rlast in 1; axi_bresp in 2; axi_rdata in 256.
REQ-003 Fixed: one clock; reset asynchronous, active-low.

Function
REQ-004 instr_mem: 256 x 128-bit array named instr_mem, directly in the top module; fields opcode[127:120], subop[119:112], dst[111:96], act[95:80], wgt[79:64], M[63:48], N[47:32], K[31:16], [15:0] reserved.
REQ-005 SRAM: instance sram_inst, generate block bank_gen[b], each bank instance bank_inst with array mem[SRAM_DEPTH] of SRAM_WIDTH bits; 16-bit address a maps to bank a[1:0], word a[9:2].
REQ-006 Opcodes: 0x00 NOP (advance); 0x01 TENSOR with subop 0x01 GEMM; 0xFF HALT; any other opcode/subop sets tpc_error and stops as for HALT.
REQ-007 GEMM operands: signed int8, lane k = bits [8k+7:8k]; A row i = bank i word of (act+i); weight bank j at (wgt+j) holds column j of B, lane k = B[k][j].
REQ-008 GEMM result C[i][j] = sum over k<ARRAY_SIZE of A[i][k]*B[k][j], signed 32-bit, written to lane j bits [32j+31:32j] of (dst+i); bits above 32*ARRAY_SIZE written zero; M/N/K fields ignored (tile fixed at ARRAY_SIZE).
REQ-009 Sequencer FSM: IDLE -> FETCH -> DECODE -> GEMM_LDW (read 4 weight words) -> GEMM_ROW (per row: read A, compute, write) -> FETCH; HALT -> DONE.
REQ-010 Start: tpc_start high while IDLE or DONE loads pc=tpc_start_pc, clears done/error, sets busy next cycle; start while busy is ignored; start held multiple cycles launches once.
REQ-011 Latency: each GEMM completes within 40 cycles; program GEMM,GEMM,HALT raises tpc_done within 100 cycles of start.
REQ-012 tpc_busy high from start acceptance until HALT/error; tpc_done high from HALT until next accepted start; tpc_done and tpc_busy never both high.
REQ-013 Back-to-back GEMMs: second GEMM reads SRAM only after the first's last write; writes to disjoint addresses never disturb other words.
REQ-014 PC wraps modulo 256.
REQ-015 NoC write-in: noc_rx_ready=1 when not busy; on valid&ready, is_instr writes instr_mem[addr[7:0]] with data[127:0], else writes SRAM per REQ-005 with addr[15:0].
REQ-016 Outputs tied: sync_request, noc_tx_valid, all AXI valid/ready/last outputs 0; noc_tx_data/addr, AXI addr/len/data 0.

Reset
REQ-017 rst_n low asynchronously: FSM IDLE, pc 0, busy/done/error 0, all tied outputs 0; mid-program reset aborts the program; instr_mem and SRAM contents are not cleared.

Structure
REQ-018 Shared package: opcode/subop constants, instruction field positions, FSM state enum.
REQ-019 One sub-module: sram_bank (single-port, 1-cycle read latency, synchronous write), instantiated SRAM_BANKS times under sram_inst.

Verification
REQ-020 A=I, B rows [1..4],[5..8],[9..12],[13..16], dst 0x20 -> SRAM words 8 of banks 0-3 hold rows of B.
REQ-021 Program GEMM(0x00/0x10->0x20), GEMM(A=2I, B rows all k+1, 0x40/0x50->0x60), HALT -> word 24 rows [2,2,2,2],[4..],[6..],[8..]; word 8 unchanged; done within 100 cycles.
REQ-022 Signed: A=-1*I, B[0][0]=-128 -> C[0][0]=128, lanes beyond 128 bits zero.
REQ-023 Opcode 0x07 -> tpc_error=1, tpc_busy=0.
REQ-024 Reset asserted mid-GEMM -> busy/done 0 immediately; restart produces correct results.
